// File: rtl/led_seq_pkg.sv
// Shared types and constants for the alarm LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        ALARM_ON  = 2'd1,
        ALARM_OFF = 2'd2,
        RESTORE   = 2'd3
    } seq_state_t;

    localparam int          LED_W_DEFAULT = 10;
    localparam int          PIO_DATA_W    = 32;
    // Wide enough for any LED_W up to the PIO data width; sliced at use.
    localparam logic [31:0] LED_ALL_ON    = 32'hFFFF_FFFF;
    localparam logic [1:0]  LED_DATA_ADDR = 2'd0;

    // Blink half-period in clock cycles; never less than one.
    function automatic int blink_half_cycles(input int clk_hz, input int half_ms);
        int cycles;
        cycles = (clk_hz / 1000) * half_ms;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/alarm_led_sequencer_if.sv
// Avalon-MM write-only link from the sequencer to the LED PIO slave.
interface alarm_led_sequencer_if;

    logic [1:0]  led_address;
    logic        led_chipselect;
    logic        led_write_n;
    logic [31:0] led_writedata;

    modport master (
        output led_address, led_chipselect, led_write_n, led_writedata
    );

    modport slave (
        input  led_address, led_chipselect, led_write_n, led_writedata
    );

endinterface

// File: rtl/led_write_engine.sv
// Change-detecting writer: issues one zero-wait-state PIO write whenever
// the desired LED value differs from what was last written.
module led_write_engine
    import led_seq_pkg::*;
#(
    parameter int LED_W = LED_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LED_W-1:0]       desired,
    alarm_led_sequencer_if.master  pio
);

    logic [LED_W-1:0] written;
    logic             cs_q;
    logic             wr_n_q;
    logic [31:0]      wdata_q;

    // Launch a single-cycle write on any difference; writedata holds between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written <= '0;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            wdata_q <= '0;
        end else if (desired != written) begin
            written <= desired;
            cs_q    <= 1'b1;
            wr_n_q  <= 1'b0;
            wdata_q <= {{(PIO_DATA_W-LED_W){1'b0}}, desired};
        end else begin
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
        end
    end

    assign pio.led_address    = LED_DATA_ADDR;
    assign pio.led_chipselect = cs_q;
    assign pio.led_write_n    = wr_n_q;
    assign pio.led_writedata  = wdata_q;

endmodule

// File: rtl/alarm_led_sequencer.sv
// Arbitrates the LED PIO between software patterns and the alarm blinker.
module alarm_led_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BLINK_HALF_MS = 250,
    parameter int LED_W         = LED_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sw_valid,
    input  logic [LED_W-1:0]       sw_pattern,
    output logic                   sw_ready,
    input  logic                   alarm_active,
    input  logic                   alarm_ack,
    output logic                   alarm_blinking,
    alarm_led_sequencer_if.master  led_pio
);

    localparam int HALF  = blink_half_cycles(CLK_HZ, BLINK_HALF_MS);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    seq_state_t       state, state_n;
    logic [CNT_W-1:0] blink_cnt;
    logic             alarm_q;
    logic [LED_W-1:0] shadow;
    logic [LED_W-1:0] shadow_next;
    logic [LED_W-1:0] desired;
    logic             sw_ready_q;
    logic             blink_q;
    logic             alarm_rise;
    logic             sw_accept;
    logic             cnt_wrap;
    logic             alarm_end;

    assign alarm_rise  = alarm_active & ~alarm_q;
    assign sw_accept   = sw_valid & sw_ready_q;
    assign shadow_next = sw_accept ? sw_pattern : shadow;
    assign cnt_wrap    = (blink_cnt == CNT_LAST);
    assign alarm_end   = alarm_ack | ~alarm_active;

    // State, edge-detect, shadow and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NORMAL;
            alarm_q    <= 1'b0;
            shadow     <= '0;
            sw_ready_q <= 1'b1;
            blink_q    <= 1'b0;
        end else begin
            state      <= state_n;
            alarm_q    <= alarm_active;
            shadow     <= shadow_next;
            sw_ready_q <= (state_n != RESTORE);
            blink_q    <= (state_n == ALARM_ON) || (state_n == ALARM_OFF);
        end
    end

    // Blink counter runs only while blinking, so entering an alarm starts from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
        end else if (state == ALARM_ON || state == ALARM_OFF) begin
            blink_cnt <= cnt_wrap ? '0 : blink_cnt + 1'b1;
        end else begin
            blink_cnt <= '0;
        end
    end

    // Next state and displayed value. In NORMAL the incoming pattern is used
    // directly so the write lands the cycle after acceptance, except when an
    // alarm is arming in the same cycle: the alarm owns the display then.
    always_comb begin
        state_n = state;
        desired = shadow;
        case (state)
            NORMAL: begin
                desired = alarm_rise ? shadow : shadow_next;
                if (alarm_rise) state_n = ALARM_ON;
            end
            ALARM_ON: begin
                desired = LED_ALL_ON[LED_W-1:0];
                if (alarm_end)     state_n = RESTORE;
                else if (cnt_wrap) state_n = ALARM_OFF;
            end
            ALARM_OFF: begin
                desired = '0;
                if (alarm_end)     state_n = RESTORE;
                else if (cnt_wrap) state_n = ALARM_ON;
            end
            RESTORE: begin
                desired = shadow;
                state_n = NORMAL;
            end
            default: state_n = NORMAL;
        endcase
    end

    led_write_engine #(.LED_W(LED_W)) u_write_engine (
        .clk     (clk),
        .reset   (reset),
        .desired (desired),
        .pio     (led_pio)
    );

    assign sw_ready       = sw_ready_q;
    assign alarm_blinking = blink_q;

endmodule

// File: tb/tb_alarm_led_sequencer.sv
// Bench for alarm_led_sequencer: directed vector table, a reset-in-write
// sequence, and random traffic against a cycle-count reference model.
module tb_alarm_led_sequencer;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_valid = 1'b0;
    logic [9:0] sw_pattern = '0;
    logic       alarm_active = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       sw_ready;
    logic       alarm_blinking;

    alarm_led_sequencer_if pio ();

    alarm_led_sequencer #(
        .CLK_HZ        (4000),
        .BLINK_HALF_MS (1),
        .LED_W         (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sw_valid       (sw_valid),
        .sw_pattern     (sw_pattern),
        .sw_ready       (sw_ready),
        .alarm_active   (alarm_active),
        .alarm_ack      (alarm_ack),
        .alarm_blinking (alarm_blinking),
        .led_pio        (pio)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [9:0] p;
        logic       a;
        logic       ack;
        logic       cs;
        logic [9:0] wd;
        logic       ready;
        logic       blink;
    } vec_t;

    vec_t tbl [24];

    // Reference model: mode 0 normal, 1 alarm, 2 restore; blink phase is
    // derived from the number of cycles spent in the alarm.
    int         m_mode;
    int         m_cyc;
    logic [9:0] m_shadow, m_written, m_wd;
    logic       m_prev, m_cs, m_ready, m_blink;

    function automatic vec_t mk(input logic v, input logic [9:0] p, input logic a,
                                input logic ack, input logic cs, input logic [9:0] wd,
                                input logic ready, input logic blink);
        vec_t r;
        r.v = v; r.p = p; r.a = a; r.ack = ack;
        r.cs = cs; r.wd = wd; r.ready = ready; r.blink = blink;
        return r;
    endfunction

    function automatic logic [63:0] pack(input logic cs, input logic wn, input logic [1:0] addr,
                                         input logic [31:0] wd, input logic rdy, input logic bl);
        return {26'b0, cs, wn, addr, wd, rdy, bl};
    endfunction

    function automatic logic [63:0] obs();
        return pack(pio.led_chipselect, pio.led_write_n, pio.led_address,
                    pio.led_writedata, sw_ready, alarm_blinking);
    endfunction

    function automatic logic [63:0] model_exp();
        return pack(m_cs, ~m_cs, 2'b00, {22'b0, m_wd}, m_ready, m_blink);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cyc = 0;
        m_shadow = '0; m_written = '0; m_wd = '0;
        m_prev = 1'b0; m_cs = 1'b0; m_ready = 1'b1; m_blink = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [9:0] p, input logic a, input logic ack);
        logic       rise, acc;
        logic [9:0] tgt;
        rise = a && !m_prev;
        acc  = v && (m_mode != 2);
        case (m_mode)
            0:       tgt = rise ? m_shadow : (acc ? p : m_shadow);
            1:       tgt = (((m_cyc / HALF) % 2) == 0) ? 10'h3FF : 10'h000;
            default: tgt = m_shadow;
        endcase
        m_cs = (tgt != m_written);
        if (m_cs) begin
            m_written = tgt;
            m_wd      = tgt;
        end
        if (acc) m_shadow = p;
        case (m_mode)
            0:       if (rise) begin m_mode = 1; m_cyc = 0; end
            1:       if (ack || !a) m_mode = 2; else m_cyc++;
            default: m_mode = 0;
        endcase
        m_prev  = a;
        m_ready = (m_mode != 2);
        m_blink = (m_mode == 1);
    endtask

    // Called at a falling edge: drive inputs, advance the model, and return at
    // the next falling edge with the DUT outputs settled.
    task automatic step(input logic v, input logic [9:0] p, input logic a, input logic ack);
        sw_valid = v; sw_pattern = p; alarm_active = a; alarm_ack = ack;
        model_step(v, p, a, ack);
        @(negedge clk);
    endtask

    initial begin
        model_reset();

        tbl[0]  = mk(1, 10'h2A5, 0, 0,  1, 10'h2A5, 1, 0);
        tbl[1]  = mk(1, 10'h2A5, 0, 0,  0, 10'h2A5, 1, 0);
        tbl[2]  = mk(0, 10'h000, 1, 0,  0, 10'h2A5, 1, 1);
        tbl[3]  = mk(0, 10'h000, 1, 0,  1, 10'h3FF, 1, 1);
        tbl[4]  = mk(0, 10'h000, 1, 0,  0, 10'h3FF, 1, 1);
        tbl[5]  = mk(1, 10'h055, 1, 0,  0, 10'h3FF, 1, 1);
        tbl[6]  = mk(0, 10'h000, 1, 0,  0, 10'h3FF, 1, 1);
        tbl[7]  = mk(0, 10'h000, 1, 0,  1, 10'h000, 1, 1);
        tbl[8]  = mk(0, 10'h000, 1, 0,  0, 10'h000, 1, 1);
        tbl[9]  = mk(0, 10'h000, 1, 1,  0, 10'h000, 0, 0);
        tbl[10] = mk(0, 10'h000, 1, 0,  1, 10'h055, 1, 0);
        tbl[11] = mk(0, 10'h000, 1, 0,  0, 10'h055, 1, 0);
        tbl[12] = mk(0, 10'h000, 1, 0,  0, 10'h055, 1, 0);
        tbl[13] = mk(0, 10'h000, 0, 0,  0, 10'h055, 1, 0);
        tbl[14] = mk(0, 10'h000, 1, 0,  0, 10'h055, 1, 1);
        tbl[15] = mk(0, 10'h000, 1, 0,  1, 10'h3FF, 1, 1);
        tbl[16] = mk(0, 10'h000, 1, 0,  0, 10'h3FF, 1, 1);
        tbl[17] = mk(0, 10'h000, 1, 0,  0, 10'h3FF, 1, 1);
        tbl[18] = mk(0, 10'h000, 1, 0,  0, 10'h3FF, 1, 1);
        tbl[19] = mk(0, 10'h000, 1, 0,  1, 10'h000, 1, 1);
        tbl[20] = mk(0, 10'h000, 1, 0,  0, 10'h000, 1, 1);
        tbl[21] = mk(0, 10'h000, 1, 0,  0, 10'h000, 1, 1);
        tbl[22] = mk(0, 10'h000, 1, 0,  0, 10'h000, 1, 1);
        tbl[23] = mk(0, 10'h000, 1, 0,  1, 10'h3FF, 1, 1);

        // Reset and idle: nothing may be written.
        repeat (3) @(negedge clk);
        chk("reset_state", obs(), pack(1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0));
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(0, 10'h000, 0, 0);
            chk("idle_no_write", obs(), pack(1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0));
        end

        // Directed vectors: sw write, no rewrite, blink, ack/restore, re-arm.
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].v, tbl[i].p, tbl[i].a, tbl[i].ack);
            chk($sformatf("vec%0d", i), obs(),
                pack(tbl[i].cs, ~tbl[i].cs, 2'b00, {22'b0, tbl[i].wd},
                     tbl[i].ready, tbl[i].blink));
        end

        // Async reset in the middle of the all-ones write cycle.
        reset = 1'b1;
        #1;
        chk("rst_midwrite_strobes", {62'b0, pio.led_chipselect, pio.led_write_n}, 64'h1);
        chk("rst_midwrite_data", {32'b0, pio.led_writedata}, 64'h0);
        chk("rst_midwrite_status", {62'b0, sw_ready, alarm_blinking}, 64'h2);
        sw_valid = 1'b0; alarm_active = 1'b0; alarm_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        // Shadow cleared: idling in NORMAL must not write anything.
        for (int i = 0; i < 3; i++) begin
            step(0, 10'h000, 0, 0);
            chk("post_reset_idle", obs(), model_exp());
        end
        // Same-cycle accept and arm: alarm owns the display, shadow keeps 0x0F0.
        step(1, 10'h0F0, 1, 0);
        chk("accept_and_arm", obs(), model_exp());
        for (int i = 0; i < 6; i++) begin
            step(0, 10'h000, 1, 0);
            chk("arm_blink", obs(), model_exp());
        end
        step(0, 10'h000, 0, 0);
        chk("alarm_low_end", obs(), model_exp());
        step(0, 10'h000, 0, 0);
        chk("restore_shadow", obs(), model_exp());
        chk("restore_value", {54'b0, pio.led_writedata[9:0]}, 64'h0F0);

        // Random traffic against the reference model.
        begin
            logic a;
            a = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 19) == 0) a = ~a;
                step(1'($urandom_range(0, 1)), 10'($urandom), a,
                     ($urandom_range(0, 14) == 0));
                chk("random", obs(), model_exp());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
